// File: rtl/sobel_stream_ctrl_pkg.sv
// Shared definitions for the Sobel stream controller.
//   MAX_PIXEL_BITS : width of one gray / Sobel pixel on every data path
//   state_e        : frame sequencer states
//   is_active()    : true while pixels are moving (stream or drain)
package sobel_stream_ctrl_pkg;

    localparam int MAX_PIXEL_BITS = 24;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    function automatic logic is_active(input state_e s);
        return (s == S_STREAM) || (s == S_DRAIN);
    endfunction

endpackage

// File: rtl/sobel_stream_ctrl_if.sv
// Pixel bus between the SPI controller, the Sobel core and the stream
// controller. Signal names are seen from the controller side.
//   master : the stream controller (drives sobel_px_o/sobel_valid_o/tx_px_o)
//   slave  : the surrounding SPI controller and Sobel core
interface sobel_stream_ctrl_if;
    import sobel_stream_ctrl_pkg::*;

    logic [MAX_PIXEL_BITS-1:0] rx_px_i;        // received gray pixel
    logic                      rx_valid_i;     // one-cycle pulse: rx_px_i valid
    logic [MAX_PIXEL_BITS-1:0] sobel_px_o;     // pixel to Sobel core
    logic                      sobel_valid_o;  // sobel_px_o valid
    logic                      sobel_ready_i;  // Sobel core accepts pixel
    logic [MAX_PIXEL_BITS-1:0] sobel_px_i;     // Sobel result
    logic                      sobel_valid_i;  // one-cycle pulse: result valid
    logic [MAX_PIXEL_BITS-1:0] tx_px_o;        // pixel for next SPI transmit
    logic                      tx_done_i;      // one-cycle pulse: SPI transfer done

    modport master (
        input  rx_px_i, rx_valid_i, sobel_ready_i, sobel_px_i, sobel_valid_i, tx_done_i,
        output sobel_px_o, sobel_valid_o, tx_px_o
    );

    modport slave (
        output rx_px_i, rx_valid_i, sobel_ready_i, sobel_px_i, sobel_valid_i, tx_done_i,
        input  sobel_px_o, sobel_valid_o, tx_px_o
    );

endinterface

// File: rtl/sobel_stream_ctrl_px.sv
// px_fifo: show-ahead synchronous FIFO with registered storage.
//   push_i/wdata_i : write; accepted when not full, or when full with a
//                    same-cycle pop
//   pop_i          : remove head; ignored when empty
//   flush_i        : empty the FIFO; wins over push/pop
//   rdata_o        : current head (undefined when empty_o)
//   full_o/empty_o : status, from pointers carrying one extra wrap bit
module px_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             nreset_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries
    // are valid, so resetting the array would only add reset fan-out.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/sobel_stream_ctrl.sv
// sobel_stream_ctrl: frame scheduler between the SPI slave and the Sobel core.
//   clk_i, nreset_i   : clock, asynchronous active-low reset
//   start_i, abort_i  : start-frame / abort-and-flush pulses (abort wins)
//   clear_err_i       : clears sticky error flags (a same-cycle set wins)
//   bus               : rx pixels in, Sobel issue/results, tx pixel out
//   busy_o            : high while streaming or draining
//   frame_done_o      : one-cycle pulse when the frame completes
//   err_rx_ovf_o      : sticky, an rx pixel was dropped
//   err_tx_ovf_o      : sticky, a Sobel result was dropped
//   err_tx_udf_o      : sticky, tx_done_i with nothing to transmit
module sobel_stream_ctrl
    import sobel_stream_ctrl_pkg::*;
#(
    parameter int FRAME_PIXELS = 64,
    parameter int IN_DEPTH     = 4,
    parameter int OUT_DEPTH    = 4
) (
    input  logic                 clk_i,
    input  logic                 nreset_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic                 clear_err_i,
    sobel_stream_ctrl_if.master  bus,
    output logic                 busy_o,
    output logic                 frame_done_o,
    output logic                 err_rx_ovf_o,
    output logic                 err_tx_ovf_o,
    output logic                 err_tx_udf_o
);
    localparam int            CW        = $clog2(FRAME_PIXELS + 1);
    localparam logic [CW-1:0] FRAME_CNT = CW'(FRAME_PIXELS);

    state_e                    state_q, state_d;
    logic [CW-1:0]             in_cnt_q, in_cnt_d;
    logic [CW-1:0]             out_cnt_q, out_cnt_d;
    logic [CW-1:0]             rx_acc_q, rx_acc_d;
    logic                      err_rx_ovf_q, err_tx_ovf_q, err_tx_udf_q;
    logic                      flush, active;
    logic                      in_push, in_pop, in_full, in_empty;
    logic                      out_push, out_pop, out_full, out_empty;
    logic [MAX_PIXEL_BITS-1:0] in_head, out_head;

    // NOTE: every signal driven here gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        flush   = 1'b0;
        if (abort_i) begin
            state_d = S_IDLE;
            flush   = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: if (start_i) begin
                    state_d = S_STREAM;
                    flush   = 1'b1;
                end
                S_STREAM: if (in_cnt_q == FRAME_CNT)  state_d = S_DRAIN;
                S_DRAIN:  if (out_cnt_q == FRAME_CNT) state_d = S_DONE;
                S_DONE:   state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    assign active = is_active(state_q);

    // Input side: accept only while streaming and the frame quota is open.
    // Any rx pulse that is not stored counts as a dropped pixel.
    assign in_pop  = active & ~in_empty & bus.sobel_ready_i;
    assign in_push = bus.rx_valid_i & (state_q == S_STREAM) &
                     (rx_acc_q != FRAME_CNT) & (~in_full | in_pop);

    // Output side: a full FIFO still accepts when tx pops in the same cycle.
    assign out_pop  = active & bus.tx_done_i & ~out_empty;
    assign out_push = active & bus.sobel_valid_i & (~out_full | out_pop);

    px_fifo #(.WIDTH(MAX_PIXEL_BITS), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk_i, .nreset_i,
        .push_i (in_push),  .pop_i  (in_pop),  .flush_i (flush),
        .wdata_i(bus.rx_px_i), .rdata_o(in_head),
        .full_o (in_full),  .empty_o(in_empty)
    );

    px_fifo #(.WIDTH(MAX_PIXEL_BITS), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk_i, .nreset_i,
        .push_i (out_push), .pop_i  (out_pop), .flush_i (flush),
        .wdata_i(bus.sobel_px_i), .rdata_o(out_head),
        .full_o (out_full), .empty_o(out_empty)
    );

    // Heads are gated to zero when empty: the storage is not reset.
    assign bus.sobel_valid_o = active & ~in_empty;
    assign bus.sobel_px_o    = bus.sobel_valid_o ? in_head : '0;
    assign bus.tx_px_o       = out_empty ? '0 : out_head;

    assign busy_o       = active;
    assign frame_done_o = (state_q == S_DONE);
    assign err_rx_ovf_o = err_rx_ovf_q;
    assign err_tx_ovf_o = err_tx_ovf_q;
    assign err_tx_udf_o = err_tx_udf_q;

    // Counters saturate at FRAME_PIXELS; flush zeroes them.
    always_comb begin
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        rx_acc_d  = rx_acc_q;
        if (flush) begin
            in_cnt_d  = '0;
            out_cnt_d = '0;
            rx_acc_d  = '0;
        end else begin
            if (in_pop  && in_cnt_q  != FRAME_CNT) in_cnt_d  = in_cnt_q  + CW'(1);
            if (out_pop && out_cnt_q != FRAME_CNT) out_cnt_d = out_cnt_q + CW'(1);
            if (in_push && rx_acc_q  != FRAME_CNT) rx_acc_d  = rx_acc_q  + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q      <= S_IDLE;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
            rx_acc_q     <= '0;
            err_rx_ovf_q <= 1'b0;
            err_tx_ovf_q <= 1'b0;
            err_tx_udf_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_cnt_q     <= in_cnt_d;
            out_cnt_q    <= out_cnt_d;
            rx_acc_q     <= rx_acc_d;
            // A set event takes priority over a same-cycle clear.
            err_rx_ovf_q <= (bus.rx_valid_i & ~in_push) | (err_rx_ovf_q & ~clear_err_i);
            err_tx_ovf_q <= (active & bus.sobel_valid_i & ~out_push) |
                            (err_tx_ovf_q & ~clear_err_i);
            err_tx_udf_q <= (active & bus.tx_done_i & out_empty) |
                            (err_tx_udf_q & ~clear_err_i);
        end
    end

endmodule
